// File: rtl/phase_scheduler_if.sv
// Handshake bundle between the routing-round scheduler and its nine pipeline stages.
interface phase_scheduler_if #(
    parameter int NUM_PHASES = 9,
    parameter int WORD_WIDTH = 16
);
    logic                  en;
    logic [NUM_PHASES-1:0] done_vec;
    logic [NUM_PHASES-1:0] abort_vec;
    logic [NUM_PHASES-1:0] start_vec;
    logic [2:0]            addr_select;
    logic [2:0]            wr_select;
    logic                  mem_wr_gate;
    logic [3:0]            phase;
    logic                  busy;
    logic                  round_done;
    logic                  aborted;
    logic                  timeout_err;
    logic [WORD_WIDTH-1:0] round_count;

    modport master (
        input  en, done_vec, abort_vec,
        output start_vec, addr_select, wr_select, mem_wr_gate, phase,
               busy, round_done, aborted, timeout_err, round_count
    );

    modport slave (
        output en, done_vec, abort_vec,
        input  start_vec, addr_select, wr_select, mem_wr_gate, phase,
               busy, round_done, aborted, timeout_err, round_count
    );
endinterface

// File: rtl/phase_scheduler.sv
// Sequences the nine routing stages per round and owns the shared-memory mux selects.
// Next start pulse 2 cycles after a stage's done edge; a stage stalls the round until done or watchdog.
module phase_scheduler #(
    parameter int                    NUM_PHASES = 9,
    parameter int                    WORD_WIDTH = 16,
    parameter int                    TIMEOUT    = 4096,
    parameter logic [NUM_PHASES-1:0] WR_MASK    = 9'b111011011
) (
    input  logic               clock,
    input  logic               rst,
    phase_scheduler_if.master  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_FINISH,
        S_ERROR
    } state_t;

    localparam int             TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  T_LAST   = TW'(TIMEOUT - 1);
    localparam logic [3:0]     LAST_P   = 4'(NUM_PHASES - 1);
    localparam logic [3:0]     PH_IDLE  = 4'hF;

    state_t                state;
    logic [3:0]            cur;
    logic [TW-1:0]         timer;
    logic [NUM_PHASES-1:0] done_q;
    logic [NUM_PHASES-1:0] start_q;
    logic [2:0]            sel_q;
    logic                  gate_q;
    logic [3:0]            phase_q;
    logic                  busy_q;
    logic                  rdone_q;
    logic                  abort_q;
    logic                  terr_q;
    logic [WORD_WIDTH-1:0] count_q;

    logic       hit;
    logic [3:0] nxt;

    // Stage 2 shares stage 1's mux leg; from stage 3 on the leg index trails the stage by one.
    function automatic logic [2:0] sel_of(input logic [3:0] p);
        logic [2:0] s;
        s = '0;
        case (p)
            4'd0:       s = 3'd0;
            4'd1, 4'd2: s = 3'd1;
            default:    s = 3'(p - 4'd1);
        endcase
        return s;
    endfunction

    // Only a rising done counts, so a level left high from an earlier round cannot complete a stage.
    assign hit = bus.done_vec[cur] & ~done_q[cur];
    assign nxt = cur + 4'd1;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cur     <= '0;
            timer   <= '0;
            done_q  <= '0;
            start_q <= '0;
            sel_q   <= '0;
            gate_q  <= 1'b0;
            phase_q <= PH_IDLE;
            busy_q  <= 1'b0;
            rdone_q <= 1'b0;
            abort_q <= 1'b0;
            terr_q  <= 1'b0;
            count_q <= '0;
        end else begin
            done_q  <= bus.done_vec;
            start_q <= '0;
            rdone_q <= 1'b0;
            abort_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.en) begin
                        state   <= S_LAUNCH;
                        cur     <= '0;
                        terr_q  <= 1'b0;
                        sel_q   <= sel_of(4'd0);
                        gate_q  <= WR_MASK[0];
                        phase_q <= 4'd0;
                        busy_q  <= 1'b1;
                    end
                end
                S_LAUNCH: begin
                    start_q <= NUM_PHASES'(1) << cur;
                    timer   <= '0;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (hit) begin
                        if (bus.abort_vec[cur] || !bus.en) begin
                            abort_q <= 1'b1;
                            state   <= S_FINISH;
                            phase_q <= PH_IDLE;
                            sel_q   <= '0;
                            gate_q  <= 1'b0;
                        end else if (cur == LAST_P) begin
                            rdone_q <= 1'b1;
                            count_q <= count_q + WORD_WIDTH'(1);
                            state   <= S_FINISH;
                            phase_q <= PH_IDLE;
                            sel_q   <= '0;
                            gate_q  <= 1'b0;
                        end else begin
                            cur     <= nxt;
                            state   <= S_LAUNCH;
                            sel_q   <= sel_of(nxt);
                            gate_q  <= WR_MASK[nxt];
                            phase_q <= nxt;
                        end
                    end else if (timer == T_LAST) begin
                        state  <= S_ERROR;
                        terr_q <= 1'b1;
                        busy_q <= 1'b0;
                        gate_q <= 1'b0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_FINISH: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
                S_ERROR: begin
                    if (!bus.en) begin
                        state   <= S_IDLE;
                        phase_q <= PH_IDLE;
                        sel_q   <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.start_vec   = start_q;
    assign bus.addr_select = sel_q;
    assign bus.wr_select   = sel_q;
    assign bus.mem_wr_gate = gate_q;
    assign bus.phase       = phase_q;
    assign bus.busy        = busy_q;
    assign bus.round_done  = rdone_q;
    assign bus.aborted     = abort_q;
    assign bus.timeout_err = terr_q;
    assign bus.round_count = count_q;
endmodule

// File: tb/tb_phase_scheduler.sv
// Bench for phase_scheduler: bench-side stage models with random delays, checked against a round-level model.
module tb_phase_scheduler;
    localparam int         NP  = 9;
    localparam logic [8:0] WRM = 9'b111011011;

    logic clock = 1'b0;
    logic rst;
    always #5 clock = ~clock;

    phase_scheduler_if #(.NUM_PHASES(NP), .WORD_WIDTH(16)) bus();

    phase_scheduler #(
        .NUM_PHASES(NP),
        .WORD_WIDTH(16),
        .TIMEOUT(16),
        .WR_MASK(WRM)
    ) dut (
        .clock(clock),
        .rst(rst),
        .bus(bus)
    );

    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    int            exp_count = 0;
    int            dly[NP];
    logic [NP-1:0] abf;
    int            sel_tab[NP] = '{0, 1, 1, 2, 3, 4, 5, 6, 7};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        cyc++;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_phase"}, 32'(bus.phase), 32'd15);
        chk({pfx, "_start"}, 32'(bus.start_vec), 32'd0);
        chk({pfx, "_addr"},  32'(bus.addr_select), 32'd0);
        chk({pfx, "_wrsel"}, 32'(bus.wr_select), 32'd0);
        chk({pfx, "_gate"},  32'(bus.mem_wr_gate), 32'd0);
        chk({pfx, "_busy"},  32'(bus.busy), 32'd0);
        chk({pfx, "_rdone"}, 32'(bus.round_done), 32'd0);
        chk({pfx, "_abort"}, 32'(bus.aborted), 32'd0);
        chk({pfx, "_terr"},  32'(bus.timeout_err), 32'd0);
        chk({pfx, "_count"}, 32'(bus.round_count), 32'd0);
    endtask

    task automatic set_dly(input int lo, input int hi);
        for (int k = 0; k < NP; k++) dly[k] = $urandom_range(hi, lo);
        abf = '0;
    endtask

    // One routing round. Negative stage arguments disable that event.
    task automatic run_round(input int drop_st, input int hang_st, input bit stale, input int rst_st);
        int         nxt, t_start, ref_c, end_c, n_rd, n_ab, c0, exp_last, outc;
        logic [3:0] s, act;
        bit         act_vld, fin;
        nxt = 0; t_start = 0; end_c = -1; n_rd = 0; n_ab = 0;
        s = '0; act = '0; act_vld = 1'b0; fin = 1'b0;

        // Round-level expectation: 0 full, 1 abort, 2 watchdog, 3 reset.
        exp_last = NP - 1;
        outc = 0;
        for (int k = 0; k < NP; k++) begin
            if (k == rst_st)  begin exp_last = k; outc = 3; break; end
            if (k == hang_st) begin exp_last = k; outc = 2; break; end
            if (abf[k] || k == drop_st) begin exp_last = k; outc = 1; break; end
        end

        bus.abort_vec = '0;
        if (stale) begin
            bus.done_vec[0] = 1'b1;
            tick();
        end
        bus.en = 1'b1;
        ref_c = cyc;
        c0 = cyc;
        while (!fin && (cyc - c0) < 400) begin
            tick();
            if (bus.start_vec != '0) begin
                for (int k = 0; k < NP; k++) if (bus.start_vec[k]) s = k[3:0];
                chk("start_onehot", 32'($countones(bus.start_vec)), 32'd1);
                chk("start_order", 32'(s), 32'(nxt));
                chk("start_latency", 32'(cyc - ref_c), 32'd2);
                chk("addr_select", 32'(bus.addr_select), 32'(sel_tab[s]));
                chk("wr_select", 32'(bus.wr_select), 32'(sel_tab[s]));
                chk("wr_gate", 32'(bus.mem_wr_gate), 32'(WRM[s]));
                chk("phase", 32'(bus.phase), 32'(s));
                chk("busy_run", 32'(bus.busy), 32'd1);
                chk("terr_run", 32'(bus.timeout_err), 32'd0);
                nxt = int'(s) + 1;
                act = s;
                act_vld = 1'b1;
                t_start = cyc;
                if (int'(s) == drop_st) bus.en = 1'b0;
                if (!(stale && s == 4'd0)) bus.done_vec[s] = 1'b0;
                if (int'(s) == rst_st) begin
                    #2 rst = 1'b1;
                    #1 chk_reset_vals("midrst");
                    bus.en = 1'b0;
                    bus.done_vec = '0;
                    fin = 1'b1;
                end
            end
            if (bus.round_done) n_rd++;
            if (bus.aborted) n_ab++;
            if ((bus.round_done || bus.aborted) && end_c < 0) begin
                chk("exit_latency", 32'(cyc - ref_c), 32'd1);
                end_c = cyc;
                bus.en = 1'b0;
            end
            if (end_c >= 0 && cyc == end_c + 1) begin
                chk("idle_phase", 32'(bus.phase), 32'd15);
                chk("idle_busy", 32'(bus.busy), 32'd0);
                chk("idle_gate", 32'(bus.mem_wr_gate), 32'd0);
                fin = 1'b1;
            end
            if (act_vld && int'(act) == hang_st) begin
                if (cyc == t_start + 15) chk("terr_early", 32'(bus.timeout_err), 32'd0);
                if (cyc == t_start + 16) begin
                    chk("terr_set", 32'(bus.timeout_err), 32'd1);
                    chk("terr_gate", 32'(bus.mem_wr_gate), 32'd0);
                    chk("terr_busy", 32'(bus.busy), 32'd0);
                    bus.en = 1'b0;
                end
                if (cyc == t_start + 17) begin
                    chk("err_idle_phase", 32'(bus.phase), 32'd15);
                    chk("terr_sticky", 32'(bus.timeout_err), 32'd1);
                    fin = 1'b1;
                end
            end else if (act_vld && !fin) begin
                if (stale && act == 4'd0 && cyc == t_start + 3) bus.done_vec[0] = 1'b0;
                if (cyc == t_start + dly[act]) begin
                    bus.done_vec[act]  = 1'b1;
                    bus.abort_vec[act] = abf[act];
                    ref_c = cyc;
                end
            end
        end
        chk("round_finished", 32'(fin), 32'd1);
        if (outc == 3) begin
            tick();
            rst = 1'b0;
            exp_count = 0;
            tick();
            chk("post_rst_count", 32'(bus.round_count), 32'(exp_count));
        end else begin
            chk("last_start", 32'(nxt - 1), 32'(exp_last));
            chk("round_done_cnt", 32'(n_rd), 32'(outc == 0));
            chk("aborted_cnt", 32'(n_ab), 32'(outc == 1));
            if (outc == 0) exp_count = (exp_count + 1) % 65536;
            chk("round_count", 32'(bus.round_count), 32'(exp_count));
        end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        bus.en = 1'b0;
        bus.done_vec = '0;
        bus.abort_vec = '0;
        tick();
        tick();
        chk_reset_vals("reset");
        rst = 1'b0;
        tick();
        tick();
        chk("idle_hold_phase", 32'(bus.phase), 32'd15);
        chk("idle_hold_busy", 32'(bus.busy), 32'd0);

        // Full round, fixed 5-cycle stages.
        for (int k = 0; k < NP; k++) dly[k] = 5;
        abf = '0;
        run_round(-1, -1, 1'b0, -1);

        // Full round, fastest stages.
        set_dly(1, 1);
        run_round(-1, -1, 1'b0, -1);

        // Early abort at stage 1.
        set_dly(1, 6);
        abf[1] = 1'b1;
        run_round(-1, -1, 1'b0, -1);

        // Abort flag together with the last stage.
        set_dly(1, 4);
        abf[8] = 1'b1;
        run_round(-1, -1, 1'b0, -1);

        // en dropped while stage 4 runs.
        set_dly(2, 6);
        run_round(4, -1, 1'b0, -1);

        // Stale done on stage 0.
        set_dly(1, 5);
        dly[0] = 6;
        run_round(-1, -1, 1'b1, -1);

        // Watchdog on stage 3, then a clean round clears the error.
        set_dly(1, 5);
        run_round(-1, 3, 1'b0, -1);
        set_dly(1, 5);
        run_round(-1, -1, 1'b0, -1);

        // Randomised rounds.
        for (int r = 0; r < 8; r++) begin
            int drop;
            set_dly(1, 9);
            abf[1] = ($urandom_range(5, 0) == 0);
            abf[2] = ($urandom_range(5, 0) == 0);
            abf[4] = ($urandom_range(5, 0) == 0);
            drop = ($urandom_range(3, 0) == 0) ? int'($urandom_range(8, 0)) : -1;
            run_round(drop, -1, 1'b0, -1);
        end

        // Asynchronous reset during stage 6, then a full round from zero.
        set_dly(2, 5);
        run_round(-1, -1, 1'b0, 6);
        set_dly(1, 5);
        run_round(-1, -1, 1'b0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
